run_detector: RTL and testbench
===============================

RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-002 Parameter RUN_LEN, default 2: run length to detect, legal range 2..16.
REQ-003 Parameter CNT_W, default 8: width of the detection counter, legal range 1..32.
REQ-004 Port clock, input, 1: rising-edge clock for all state.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port x_valid, input, 1: qualifies x; when low, the sample is ignored.
REQ-007 Port x, input, 1: serial input bit.
REQ-008 Port mode, input, 2: 00 = detect runs of either value, 01 = ones only, 10 = zeros only, 11 = detection disabled.
REQ-009 Port overlap, input, 1: 1 = overlapping detection, 0 = restart the run after each detection.
REQ-010 Port clear, input, 1: synchronous clear of det_count only.
REQ-011 Port y, output, 1: registered one-cycle detection pulse.
REQ-012 Port y_val, output, 1: value of the detected run; meaningful only while y=1.
REQ-013 Port det_count, output, CNT_W: saturating count of detections.

Function
REQ-014 Internal state SHALL be: last (1b), have_prev (1b), and run (clog2(RUN_LEN+1) bits, range 0..RUN_LEN-1).
REQ-015 A sample SHALL be accepted on any rising edge where x_valid=1 and reset=0; no state SHALL change on other edges except y (cleared) and det_count (clear).
REQ-016 On an accepted sample, run_next SHALL be 1 when have_prev=0 or x!=last, and run+1 otherwise; last SHALL become x and have_prev SHALL become 1.
REQ-017 A hit SHALL occur when run_next==RUN_LEN and mode enables value x (00: both; 01: x=1; 10: x=0; 11: neither).
REQ-018 On a hit, y SHALL be 1 and y_val SHALL equal x on the edge that accepts the sample, so y is visible in the following cycle (latency 1); otherwise y SHALL be 0.
REQ-019 After a hit with overlap=0, run SHALL become 0 and have_prev SHALL become 0, so the next sample starts a fresh run.
REQ-020 After a hit with overlap=1, run SHALL become RUN_LEN-1, so every further equal bit hits.
REQ-021 When run_next==RUN_LEN and the value is not enabled, run SHALL saturate at RUN_LEN-1 without a hit, so a mode change fires on the next equal bit.
REQ-022 mode and overlap SHALL be sampled on each accepted sample; a change SHALL NOT reset run tracking.
REQ-023 y SHALL be 0 in every cycle following a non-accepted edge; y SHALL never be high for two cycles unless two consecutive samples hit.
REQ-024 det_count SHALL increment by 1 on each hit and saturate at 2^CNT_W-1.
REQ-025 When clear=1, det_count SHALL become 0; a hit on the same edge SHALL NOT be counted (clear wins). y SHALL still pulse.
REQ-026 With RUN_LEN=2, mode=00 and overlap=0, the y sequence SHALL be cycle-identical to the team's existing pair detector.

Reset
REQ-027 On reset=1 at a rising edge, the block SHALL set y=0, y_val=0, det_count=0, run=0, last=0 and have_prev=0, regardless of x_valid and clear.
REQ-028 Reset asserted mid-run SHALL discard the partial run; the first sample after reset SHALL start a run of length 1.

Structure
REQ-029 The mode encodings (MODE_BOTH, MODE_ONES, MODE_ZEROS, MODE_OFF) SHALL be constants in the shared package run_det_pkg.
REQ-030 det_count SHALL be implemented in a sub-module sat_counter (parameter W; inputs clock, reset, clr, inc; output q), with clr priority over inc.
REQ-031 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from inputs to outputs.

Verification
REQ-032 Defaults, mode=00, overlap=0, x=1,1,1,1,0,0 -> y pulses after the 2nd, 4th and 6th samples; y_val=1,1,0; det_count=3.
REQ-033 RUN_LEN=3, overlap=1, mode=01, x=1,1,1,1,1 -> y pulses after samples 3, 4 and 5; x=0,0,0 then gives no pulse.
REQ-034 RUN_LEN=3, mode=11, x=0,0,0,0, then mode=10 and x=0 -> the only pulse follows the 5th sample, with y_val=0.
REQ-035 x_valid toggling 1,0,0,1 with x=1 on the valid cycles, defaults -> one pulse after the 2nd valid sample; y=0 during the gaps.
REQ-036 CNT_W=2, 5 hits with clear=1 on the edge of hit 5 -> det_count 1,2,3,3, then 0.
REQ-037 Reset asserted after one sample of x=1, then x=1 -> no pulse; a further x=1 -> pulse.

Source files
------------

// File: rtl/run_det_pkg.sv
// run_det_pkg: mode encodings and mode-enable helper shared by the run detector
package run_det_pkg;
  localparam logic [1:0] MODE_BOTH  = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_ZEROS = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;
  function automatic logic mode_en(input logic [1:0] m, input logic b);
    return (m == MODE_BOTH) || (m == MODE_ONES && b) || (m == MODE_ZEROS && !b);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with clear taking priority over increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clock)
    q <= (reset || clr) ? '0 : (inc && q != '1) ? q + W'(1) : q;
endmodule

// File: rtl/run_detector.sv
// run_detector: flags runs of RUN_LEN equal valid bits, with mode filter, overlap and hit counter
module run_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_valid,
  input  logic             x,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clear,
  output logic             y,
  output logic             y_val,
  output logic [CNT_W-1:0] det_count
);
  localparam int RW = $clog2(RUN_LEN + 1);
  logic          last, have_prev, hit, full;
  logic [RW-1:0] run, run_nxt;
  always_comb begin
    run_nxt = (!have_prev || x != last) ? RW'(1) : run + RW'(1);
    full    = run_nxt == RW'(RUN_LEN);
    hit     = x_valid && full && mode_en(mode, x);
  end
  // a disabled full run parks at RUN_LEN-1 so a later mode change fires on the next equal bit
  always_ff @(posedge clock) begin
    if (reset) begin
      y         <= 1'b0;
      y_val     <= 1'b0;
      last      <= 1'b0;
      have_prev <= 1'b0;
      run       <= '0;
    end else begin
      y <= hit;
      if (hit) y_val <= x;
      if (x_valid) begin
        last      <= x;
        have_prev <= !(hit && !overlap);
        run       <= (hit && !overlap) ? '0 : full ? RW'(RUN_LEN - 1) : run_nxt;
      end
    end
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (clear),
    .inc  (hit),
    .q    (det_count)
  );
endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector: directed tests over default, RUN_LEN=3 and CNT_W=2 instances sharing one stimulus
module tb_run_detector;
  import run_det_pkg::*;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       x_valid = 1'b0;
  logic       x = 1'b0;
  logic [1:0] mode = MODE_BOTH;
  logic       overlap = 1'b0;
  logic       clear = 1'b0;
  logic       y0, yv0, y3, yv3, yc, yvc;
  logic [7:0] cnt0, cnt3;
  logic [1:0] cntc;
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  run_detector u0 (.clock(clock), .reset(reset), .x_valid(x_valid), .x(x), .mode(mode),
    .overlap(overlap), .clear(clear), .y(y0), .y_val(yv0), .det_count(cnt0));
  run_detector #(.RUN_LEN(3)) u3 (.clock(clock), .reset(reset), .x_valid(x_valid), .x(x),
    .mode(mode), .overlap(overlap), .clear(clear), .y(y3), .y_val(yv3), .det_count(cnt3));
  run_detector #(.CNT_W(2)) uc (.clock(clock), .reset(reset), .x_valid(x_valid), .x(x),
    .mode(mode), .overlap(overlap), .clear(clear), .y(yc), .y_val(yvc), .det_count(cntc));

  task automatic drive(input logic v, input logic b, input logic c);
    @(negedge clock);
    reset = 1'b0; x_valid = v; x = b; clear = c;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; x_valid = 1'b1; x = 1'b1; clear = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0; x_valid = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 1, 0);
    drive(1, 1, 0);
    do_reset();
    tests++;
    if (y0 !== 1'b0 || yv0 !== 1'b0 || cnt0 !== 8'd0) begin
      fails++;
      $display("FAIL reset: y=%b y_val=%b cnt=%0d expected 0 0 0", y0, yv0, cnt0);
    end
    tests++;
    if (cnt3 !== 8'd0 || cntc !== 2'd0) begin
      fails++;
      $display("FAIL reset_cnt: cnt3=%0d cntc=%0d expected 0 0", cnt3, cntc);
    end
  endtask

  task automatic test_basic();
    logic xs[6] = '{1, 1, 1, 1, 0, 0};
    logic ye[6] = '{0, 1, 0, 1, 0, 1};
    logic ve[6] = '{0, 1, 0, 1, 0, 0};
    do_reset();
    mode = MODE_BOTH; overlap = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, xs[i], 0);
      tests++;
      if (y0 !== ye[i]) begin
        fails++;
        $display("FAIL basic_y[%0d]: y=%b expected %b", i, y0, ye[i]);
      end
      if (ye[i]) begin
        tests++;
        if (yv0 !== ve[i]) begin
          fails++;
          $display("FAIL basic_yval[%0d]: y_val=%b expected %b", i, yv0, ve[i]);
        end
      end
    end
    tests++;
    if (cnt0 !== 8'd3) begin
      fails++;
      $display("FAIL basic_cnt: det_count=%0d expected 3", cnt0);
    end
  endtask

  task automatic test_overlap();
    logic ye[8] = '{0, 0, 1, 1, 1, 0, 0, 0};
    logic xs[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    do_reset();
    mode = MODE_ONES; overlap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, xs[i], 0);
      tests++;
      if (y3 !== ye[i]) begin
        fails++;
        $display("FAIL overlap_y[%0d]: y=%b expected %b", i, y3, ye[i]);
      end
    end
    tests++;
    if (cnt3 !== 8'd3) begin
      fails++;
      $display("FAIL overlap_cnt: det_count=%0d expected 3", cnt3);
    end
  endtask

  task automatic test_mode_off();
    do_reset();
    mode = MODE_OFF; overlap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      tests++;
      if (y3 !== 1'b0) begin
        fails++;
        $display("FAIL mode_off_y[%0d]: y=%b expected 0", i, y3);
      end
    end
    mode = MODE_ZEROS;
    drive(1, 0, 0);
    tests++;
    if (y3 !== 1'b1 || yv3 !== 1'b0) begin
      fails++;
      $display("FAIL mode_change: y=%b y_val=%b expected 1 0", y3, yv3);
    end
    drive(0, 0, 0);
    tests++;
    if (y3 !== 1'b0) begin
      fails++;
      $display("FAIL mode_change_drop: y=%b expected 0", y3);
    end
  endtask

  task automatic test_gaps();
    logic vs[4] = '{1, 0, 0, 1};
    logic ye[4] = '{0, 0, 0, 1};
    do_reset();
    mode = MODE_BOTH; overlap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(vs[i], vs[i], 0);
      tests++;
      if (y0 !== ye[i]) begin
        fails++;
        $display("FAIL gaps_y[%0d]: y=%b expected %b", i, y0, ye[i]);
      end
    end
    tests++;
    if (cnt0 !== 8'd1 || yv0 !== 1'b1) begin
      fails++;
      $display("FAIL gaps_cnt: det_count=%0d y_val=%b expected 1 1", cnt0, yv0);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] ce[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    mode = MODE_BOTH; overlap = 1'b1;
    drive(1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0);
      tests++;
      if (yc !== 1'b1 || cntc !== ce[i]) begin
        fails++;
        $display("FAIL sat_cnt[%0d]: y=%b det_count=%0d expected 1 %0d", i, yc, cntc, ce[i]);
      end
    end
    drive(1, 1, 1);
    tests++;
    if (yc !== 1'b1 || cntc !== 2'd0) begin
      fails++;
      $display("FAIL clear_wins: y=%b det_count=%0d expected 1 0", yc, cntc);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    mode = MODE_BOTH; overlap = 1'b0;
    drive(1, 1, 0);
    do_reset();
    tests++;
    if (y0 !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset_y: y=%b expected 0", y0);
    end
    drive(1, 1, 0);
    tests++;
    if (y0 !== 1'b0) begin
      fails++;
      $display("FAIL midrun_first: y=%b expected 0", y0);
    end
    drive(1, 1, 0);
    tests++;
    if (y0 !== 1'b1) begin
      fails++;
      $display("FAIL midrun_second: y=%b expected 1", y0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_mode_off();
    test_gaps();
    test_saturate();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
